fir_coef_loader: RTL and testbench
==================================

Name: fir_coef_loader

Overview:
- Producer end of the FIR coefficient path.
- Accepts a coefficient set over a valid/ready stream, typically from the register interface, and buffers it in a local shadow memory.
- On commit, serially shifts the set into the tap chain's shadow coefficient registers, then issues a single swap pulse so all taps switch to the new set in the same cycle.
- Sits between the control interface and the firtap chain.

Parameters:
- COEFW, 18, coefficient width; must match the tap COEFW.
- NTAPS, 32, number of taps in the chain and coefficients per set.
- ADDRW, $clog2(NTAPS), buffer address and counter width (derived, not overridden).

Ports:
- clk  in  1  single clock for all logic.
- rstn  in  1  asynchronous, active-low reset.
- s_coef  in  COEFW  coefficient word, signed two's complement, passed through unmodified.
- s_valid  in  1  s_coef valid.
- s_last  in  1  marks the final word of a set.
- s_ready  out  1  loader accepts a word.
- commit  in  1  single-cycle request to load the buffered set into the taps.
- err_clr  in  1  clears err_len.
- busy  out  1  high while shifting or swapping.
- full  out  1  a complete, valid set is buffered.
- err_len  out  1  sticky flag: last set had the wrong length.
- coef_out  out  COEFW  coefficient driven into the head of the tap chain (tap 0).
- coef_shift  out  1  tap chain shift enable.
- coef_swap  out  1  one-cycle pulse: taps copy shadow registers to active.

Behaviour:
- Reset (rstn low, asynchronous): state FILL, counters 0, full=0, err_len=0, busy=0, coef_shift=0, coef_swap=0, coef_out=0, s_ready=0 while rstn is low.
- Buffer contents are not reset.
- Handshake: a word is accepted on any rising edge with s_valid && s_ready. s_ready is combinational from state and full only, never from s_valid.
- FILL state: s_ready = !full.
  - Each accepted word is written to buf[wr_cnt]; wr_cnt increments.
  - Accepted word with s_last and wr_cnt==NTAPS-1: full=1, wr_cnt=0.
  - Accepted word with s_last and wr_cnt<NTAPS-1 (short set): err_len=1, set discarded, wr_cnt=0, full stays 0.
  - Accepted word without s_last and wr_cnt==NTAPS-1 (long set): err_len=1, set discarded, wr_cnt=0. Subsequent words begin a new set.
- Commit in FILL:
  - If full is already 1 at the sampling edge, go to SHIFT.
  - Otherwise commit is ignored, with no flag raised.
  - commit coincident with the completing s_last beat is ignored, because full was still 0 at that edge.
- SHIFT state: s_ready=0, busy=1.
  - For exactly NTAPS consecutive cycles, coef_shift=1 and coef_out=buf[NTAPS-1-k] for k=0..NTAPS-1, so buf[0] ends at tap 0 and buf[NTAPS-1] ends at tap NTAPS-1.
  - coef_out is registered and aligned with coef_shift in the same cycle.
  - Then go to SWAP.
- SWAP state: one cycle with coef_swap=1, busy=1. Then full=0 and return to FILL.
- Latency: commit sampled at edge E gives coef_shift high in cycles E+1..E+NTAPS, coef_swap in cycle E+NTAPS+1, and busy=0 / s_ready=1 from E+NTAPS+2.
- commit during SHIFT/SWAP is ignored.
- err_len:
  - Sticky; cleared by err_clr.
  - If err_clr and a new error occur in the same cycle, the set wins (err_len=1).
- coef_out holds its last value when coef_shift=0.
- coef_shift and coef_swap are never high in the same cycle.
- Reset mid-SHIFT: outputs go to reset values immediately. The taps keep their old active set because no swap was issued. The buffer set is lost (full=0).

Decomposition:
- Shared package fir_pkg:
  - COEFW default constant.
  - State enum {FILL, SHIFT, SWAP}.
- One sub-module, coef_buf: simple dual-port RAM, NTAPS x COEFW, one write port, registered read port.
  - The loader issues the read address one cycle ahead so coef_out aligns with coef_shift.
- The FSM, counters and flags stay in fir_coef_loader.

Test Plan (NTAPS=4, COEFW=18):
- Load 1,2,3,4 with s_last on 4, then commit → full=1 after beat 4; coef_shift high 4 cycles with coef_out 4,3,2,1; coef_swap one cycle later; full=0; s_ready=1 two cycles after the last shift.
- Send 3 words with s_last on the 3rd → err_len=1, full=0. A following commit produces no coef_shift. err_clr then gives err_len=0.
- Send 5 words with no s_last, then 5,6,7,8 (s_last on 8) → err_len=1 after word 4. Words 5..8 form a valid set; full=1; commit shifts out 8,7,6,5.
- With full=1, hold s_valid high → s_ready=0 and no overwrite. commit then shifts the original set. commit pulsed during SHIFT → ignored, exactly 4 shifts and 1 swap.
- commit in the same cycle as the completing s_last → ignored. A later commit works normally.
- rstn low during the 2nd shift cycle → coef_shift, busy and full drop asynchronously to 0; coef_swap is never asserted; after release s_ready=1 and a new set loads correctly.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants and state encoding for the FIR coefficient path.
package fir_pkg;

  localparam int COEFW_DEF = 18;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    SHIFT = 2'd1,
    SWAP  = 2'd2
  } state_e;

endpackage

// File: rtl/coef_buf.sv
// Shadow coefficient buffer: one write port, one enabled registered read port.
module coef_buf #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 18,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Only the read register is reset; it doubles as the tap-chain head driver.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fir_coef_loader.sv
// Buffers a coefficient set from a stream, then shifts it into the tap chain and pulses swap.
module fir_coef_loader
  import fir_pkg::*;
#(
  parameter int COEFW = COEFW_DEF,
  parameter int NTAPS = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [COEFW-1:0] s_coef,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  input  logic             commit,
  input  logic             err_clr,
  output logic             busy,
  output logic             full,
  output logic             err_len,
  output logic [COEFW-1:0] coef_out,
  output logic             coef_shift,
  output logic             coef_swap
);

  localparam int ADDRW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam logic [ADDRW-1:0] LAST_IDX = ADDRW'(NTAPS - 1);

  state_e           state_q, state_d;
  logic [ADDRW-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDRW-1:0] sh_cnt_q, sh_cnt_d;
  logic             full_q, full_d;
  logic             err_len_q, err_len_d;

  logic             accept;
  logic             last_slot;
  logic             set_err;
  logic             rd_en;
  logic [ADDRW-1:0] rd_addr;

  assign s_ready    = rstn && (state_q == FILL) && !full_q;
  assign accept     = s_valid && s_ready;
  assign last_slot  = (wr_cnt_q == LAST_IDX);
  assign busy       = (state_q != FILL);
  assign coef_shift = (state_q == SHIFT);
  assign coef_swap  = (state_q == SWAP);
  assign full       = full_q;
  assign err_len    = err_len_q;

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    sh_cnt_d = sh_cnt_q;
    full_d   = full_q;
    set_err  = 1'b0;
    rd_en    = 1'b0;
    rd_addr  = LAST_IDX;
    case (state_q)
      FILL: begin
        if (accept) begin
          if (s_last && last_slot) begin
            full_d   = 1'b1;
            wr_cnt_d = '0;
          end else if (s_last || last_slot) begin
            // Short or long set: drop it and restart at slot 0.
            set_err  = 1'b1;
            wr_cnt_d = '0;
          end else begin
            wr_cnt_d = wr_cnt_q + ADDRW'(1);
          end
        end
        // The first read is issued on the commit edge so data meets the first shift cycle.
        if (commit && full_q) begin
          state_d  = SHIFT;
          sh_cnt_d = '0;
          rd_en    = 1'b1;
          rd_addr  = LAST_IDX;
        end
      end
      SHIFT: begin
        sh_cnt_d = sh_cnt_q + ADDRW'(1);
        if (sh_cnt_q == LAST_IDX) begin
          state_d = SWAP;
        end else begin
          rd_en   = 1'b1;
          rd_addr = LAST_IDX - ADDRW'(1) - sh_cnt_q;
        end
      end
      SWAP: begin
        full_d  = 1'b0;
        state_d = FILL;
      end
      default: begin
        state_d = FILL;
      end
    endcase
    err_len_d = (err_len_q && !err_clr) || set_err;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= FILL;
      wr_cnt_q  <= '0;
      sh_cnt_q  <= '0;
      full_q    <= 1'b0;
      err_len_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      sh_cnt_q  <= sh_cnt_d;
      full_q    <= full_d;
      err_len_q <= err_len_d;
    end
  end

  coef_buf #(
    .DEPTH (NTAPS),
    .WIDTH (COEFW),
    .AW    (ADDRW)
  ) u_coef_buf (
    .clk       (clk),
    .rstn      (rstn),
    .wr_en_i   (accept),
    .wr_addr_i (wr_cnt_q),
    .wr_data_i (s_coef),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_addr),
    .rd_data_o (coef_out)
  );

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed bench for fir_coef_loader with NTAPS=4, COEFW=18.
module tb_fir_coef_loader;

  localparam int COEFW = 18;
  localparam int NTAPS = 4;

  logic             clk = 1'b0;
  logic             rstn;
  logic [COEFW-1:0] s_coef;
  logic             s_valid;
  logic             s_last;
  logic             s_ready;
  logic             commit;
  logic             err_clr;
  logic             busy;
  logic             full;
  logic             err_len;
  logic [COEFW-1:0] coef_out;
  logic             coef_shift;
  logic             coef_swap;

  int checks   = 0;
  int failures = 0;

  fir_coef_loader #(
    .COEFW (COEFW),
    .NTAPS (NTAPS)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .s_coef     (s_coef),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .commit     (commit),
    .err_clr    (err_clr),
    .busy       (busy),
    .full       (full),
    .err_len    (err_len),
    .coef_out   (coef_out),
    .coef_shift (coef_shift),
    .coef_swap  (coef_swap)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [COEFW-1:0] d, input logic last);
    s_valid = 1'b1;
    s_coef  = d;
    s_last  = last;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Commit a full buffer and verify the shift/swap sequence; e0 is expected first on coef_out.
  task automatic commit_and_check(input string tag,
                                  input logic [COEFW-1:0] e0, input logic [COEFW-1:0] e1,
                                  input logic [COEFW-1:0] e2, input logic [COEFW-1:0] e3,
                                  input bit mid_commit);
    logic [COEFW-1:0] exp_out [4];
    exp_out[0] = e0; exp_out[1] = e1; exp_out[2] = e2; exp_out[3] = e3;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    for (int k = 0; k < NTAPS; k++) begin
      check({tag, "_shift"}, coef_shift, 1'b1);
      check({tag, "_out"}, coef_out, exp_out[k]);
      check({tag, "_noswap"}, coef_swap, 1'b0);
      check({tag, "_busy"}, busy, 1'b1);
      commit = (mid_commit && k == 1);
      tick();
    end
    commit = 1'b0;
    check({tag, "_swap"}, coef_swap, 1'b1);
    check({tag, "_swap_noshift"}, coef_shift, 1'b0);
    check({tag, "_swap_busy"}, busy, 1'b1);
    tick();
    check({tag, "_post_swap"}, coef_swap, 1'b0);
    check({tag, "_post_shift"}, coef_shift, 1'b0);
    check({tag, "_post_busy"}, busy, 1'b0);
    check({tag, "_post_full"}, full, 1'b0);
    check({tag, "_post_ready"}, s_ready, 1'b1);
    check({tag, "_hold_out"}, coef_out, e3);
  endtask

  initial begin
    rstn    = 1'b0;
    s_coef  = '0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    commit  = 1'b0;
    err_clr = 1'b0;
    #2;
    check("rst_ready", s_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_full", full, 1'b0);
    check("rst_err", err_len, 1'b0);
    check("rst_shift", coef_shift, 1'b0);
    check("rst_swap", coef_swap, 1'b0);
    check("rst_out", coef_out, '0);
    tick();
    rstn = 1'b1;
    tick();
    check("ready_after_rst", s_ready, 1'b1);

    // Basic load 1,2,3,4 and commit
    send(18'd1, 1'b0);
    send(18'd2, 1'b0);
    send(18'd3, 1'b0);
    check("t1_not_full", full, 1'b0);
    send(18'd4, 1'b1);
    check("t1_full", full, 1'b1);
    check("t1_ready_low", s_ready, 1'b0);
    commit_and_check("t1", 18'd4, 18'd3, 18'd2, 18'd1, 1'b0);

    // Short set
    send(18'd9, 1'b0);
    send(18'd9, 1'b0);
    send(18'd9, 1'b1);
    check("t2_err", err_len, 1'b1);
    check("t2_full", full, 1'b0);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    check("t2_no_shift", coef_shift, 1'b0);
    check("t2_no_busy", busy, 1'b0);
    tick();
    check("t2_no_shift2", coef_shift, 1'b0);
    check("t2_err_sticky", err_len, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t2_err_clr", err_len, 1'b0);

    // Long set followed by a valid set 5,6,7,8
    send(18'd1, 1'b0);
    send(18'd2, 1'b0);
    send(18'd3, 1'b0);
    check("t3_err_before", err_len, 1'b0);
    send(18'd4, 1'b0);
    check("t3_err_long", err_len, 1'b1);
    check("t3_not_full", full, 1'b0);
    send(18'd5, 1'b0);
    send(18'd6, 1'b0);
    send(18'd7, 1'b0);
    send(18'd8, 1'b1);
    check("t3_full", full, 1'b1);
    commit_and_check("t3", 18'd8, 18'd7, 18'd6, 18'd5, 1'b0);

    // err_clr coincident with a new error: error wins
    err_clr = 1'b1;
    send(18'd3, 1'b1);
    err_clr = 1'b0;
    check("t3b_err_wins", err_len, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t3b_err_clr", err_len, 1'b0);

    // Back-pressure when full, commit during SHIFT ignored
    send(18'h00015, 1'b0);
    send(18'h00016, 1'b0);
    send(18'h00017, 1'b0);
    send(18'h00018, 1'b1);
    s_valid = 1'b1;
    s_coef  = 18'h3FFFF;
    s_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t4_ready_full", s_ready, 1'b0);
      tick();
    end
    check("t4_still_full", full, 1'b1);
    check("t4_no_err", err_len, 1'b0);
    s_valid = 1'b0;
    s_last  = 1'b0;
    commit_and_check("t4", 18'h00018, 18'h00017, 18'h00016, 18'h00015, 1'b1);
    tick();
    check("t4_no_extra_shift", coef_shift, 1'b0);
    check("t4_no_extra_busy", busy, 1'b0);

    // commit coincident with the completing s_last is ignored
    send(18'd31, 1'b0);
    send(18'd32, 1'b0);
    send(18'd33, 1'b0);
    s_valid = 1'b1;
    s_coef  = 18'd34;
    s_last  = 1'b1;
    commit  = 1'b1;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    commit  = 1'b0;
    check("t5_full", full, 1'b1);
    check("t5_no_shift", coef_shift, 1'b0);
    check("t5_no_busy", busy, 1'b0);
    tick();
    check("t5_no_shift2", coef_shift, 1'b0);
    commit_and_check("t5", 18'd34, 18'd33, 18'd32, 18'd31, 1'b0);

    // Reset during the second shift cycle
    send(18'd41, 1'b0);
    send(18'd42, 1'b0);
    send(18'd43, 1'b0);
    send(18'd44, 1'b1);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    check("t6_shift1", coef_shift, 1'b1);
    tick();
    check("t6_shift2", coef_shift, 1'b1);
    rstn = 1'b0;
    #1;
    check("t6_rst_shift", coef_shift, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_full", full, 1'b0);
    check("t6_rst_swap", coef_swap, 1'b0);
    check("t6_rst_out", coef_out, '0);
    check("t6_rst_ready", s_ready, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t6_rst_hold_swap", coef_swap, 1'b0);
    end
    rstn = 1'b1;
    tick();
    check("t6_rel_swap", coef_swap, 1'b0);
    check("t6_rel_ready", s_ready, 1'b1);
    check("t6_rel_full", full, 1'b0);
    send(18'h20000, 1'b0);
    send(18'h00001, 1'b0);
    send(18'h3FFFF, 1'b0);
    send(18'h15555, 1'b1);
    check("t6_full", full, 1'b1);
    commit_and_check("t6", 18'h15555, 18'h3FFFF, 18'h00001, 18'h20000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
